// File: rtl/serial_addsub8_if.sv
// serial_addsub8_if: operand/result bundle for the bit-serial add/subtract unit.
// Ports (via modports):
//   master drives start, sub, a, b and observes busy, done, result and flags.
//   slave  (the unit) observes start, sub, a, b and drives busy, done, result,
//          carry, overflow, zero, negative.
interface serial_addsub8_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry, overflow, zero, negative
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry, overflow, zero, negative
    );
endinterface

// File: rtl/serial_addsub8.sv
// serial_addsub8: bit-serial WIDTH-bit add/subtract through one full-adder cell.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - serial_addsub8_if.slave: start/sub/a/b in; busy/done/result and
//           carry/overflow/zero/negative flags out (held until the next done)
module fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub8 #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    serial_addsub8_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             s;
    logic             cout;
    logic             last;
    logic [WIDTH-1:0] sum_next;

    fulladd u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (c),
        .s   (s),
        .cout(cout)
    );

    // Sum bits enter at the MSB so after WIDTH shifts the word is aligned.
    assign sum_next = {s, sum_sh[WIDTH-1:1]};
    assign last     = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            sum_sh       <= '0;
            cnt          <= '0;
            c            <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.carry    <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b0;
            bus.negative <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        // Subtraction is a + ~b + 1; the +1 rides in on the carry flop.
                        b_sh     <= bus.sub ? ~bus.b : bus.b;
                        c        <= bus.sub;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= sum_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    c      <= cout;
                    cnt    <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        bus.result   <= sum_next;
                        bus.carry    <= cout;
                        // c is still the carry into the MSB on this edge.
                        bus.overflow <= c ^ cout;
                        bus.zero     <= (sum_next == '0);
                        bus.negative <= s;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub8.sv
// tb_serial_addsub8: directed self-checking bench for serial_addsub8.
module tb_serial_addsub8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_addsub8_if #(.WIDTH(8)) bus ();

    serial_addsub8 #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] r,
                              input logic c, input logic v, input logic z, input logic n);
        chk({tag, ".result"}, 32'(bus.result), 32'(r));
        chk({tag, ".carry"}, 32'(bus.carry), 32'(c));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(v));
        chk({tag, ".zero"}, 32'(bus.zero), 32'(z));
        chk({tag, ".negative"}, 32'(bus.negative), 32'(n));
    endtask

    // Caller must be away from the clock edge. Returns #1 after the edge that drops busy.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] r,
                          input logic c, input logic v, input logic z, input logic n);
        int edges;
        bus.a = a;
        bus.b = b;
        bus.sub = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        bus.sub = ~s;
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.done && edges < 20);
        chk({tag, ".latency"}, 32'(edges), 32'd8);
        check_outs(tag, r, c, v, z, n);
        @(posedge clk);
        #1;
        chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, ".done_end"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int ndone;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        check_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add1", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("sub_borrow", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);

        // Start while busy is ignored.
        bus.a = 8'h10;
        bus.b = 8'h20;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.a = 8'hFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("busy_start.ndone", 32'(ndone), 32'd1);
        check_outs("busy_start", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("add_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        // Outputs hold through the next RUN, then reset aborts it.
        bus.a = 8'h11;
        bus.b = 8'h22;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("hold", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.busy", 32'(bus.busy), 32'd0);
        chk("mid_rst.done", 32'(bus.done), 32'd0);
        check_outs("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) ndone++;
        end
        chk("mid_rst.no_done", 32'(ndone), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_addsub8.md
Name: serial_addsub8

Overview:
- Bit-serial add/subtract unit for the 8-bit ALU datapath.
- It wraps one instance of the team's single-bit full-adder cell (fulladd). The operands are shifted through that cell one bit per clock, LSB first, and a flopped carry closes the loop.
- It sits between the ALU operand registers and the flag/result writeback stage. It gives an area-minimal alternative to the 8-cell ripple adder and produces result plus C/V/Z/N flags.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in flight, including the DONE cycle.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  sum/difference; held until the next done.
- carry  output  1  carry out of the MSB. For sub, 1 = no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low, and acts immediately.
- Reset values: state IDLE, busy 0, done 0, result 0, carry/overflow/zero/negative 0. All internal shift registers, bit counter and carry flop are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Latch a into the A shift register.
  - Latch b, or ~b when sub=1, into the B shift register.
  - Set the carry flop to sub (two's-complement +1). Clear the bit counter.
  - Go to RUN; busy goes high.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - The fulladd inputs are the A LSB, the B LSB and the carry flop.
  - Shift the sum in at the MSB of the internal sum register, shifting right.
  - Shift A and B right. Load cout into the carry flop. Increment the counter.
  - On the edge that processes bit WIDTH-1 (edge E0+WIDTH), register in the same edge:
    - result from the completed sum register;
    - carry from the final cout;
    - overflow from the final cin XOR the final cout;
    - zero and negative from the final sum.
  - Assert done and go to DONE.
- DONE: lasts one cycle. At edge E0+WIDTH+1, done goes to 0, busy goes to 0, and the state returns to IDLE.
- Latency: done is high in the cycle WIDTH edges after the start edge. The minimum issue interval is WIDTH+2 cycles.
- start while busy (RUN or DONE): ignored, with no queueing. a/b/sub changes during RUN have no effect.
- Output hold: result and flags change only on the completing edge. Between operations they hold the previous values, and they stay stable throughout the next RUN.
- Width rules: WIDTH-bit modular arithmetic; the carry out of the MSB is reported only through carry.
- Reset mid-operation: abort immediately, return all registers to their reset values, and produce no done pulse. A start is accepted on the first edge after rst_n deasserts.
- The counter is clog2(WIDTH) bits wide and never wraps within an operation.

Test Plan:
- Reset, then start with a=8'h3C, b=8'h0F, sub=0 at edge 0 -> busy=1 from edge 0; done=1 exactly after edge 8; result=8'h4B, carry=0, overflow=0, zero=0, negative=0; busy=0 after edge 9.
- a=8'h7F, b=8'h01, sub=0 -> result=8'h80, overflow=1, negative=1, carry=0.
- a=8'hFF, b=8'h01, sub=0 -> result=8'h00, carry=1, zero=1, overflow=0.
- Subtraction:
  - a=8'h05, b=8'h07, sub=1 -> result=8'hFE, carry=0 (borrow), negative=1, overflow=0.
  - a=8'h80, b=8'h01, sub=1 -> result=8'h7F, overflow=1, carry=1.
- Busy/reset handling:
  - Start 8'h10+8'h20, then pulse start with a=8'hFF at cycle 3 -> second start ignored, result=8'h30, and exactly one done pulse.
  - A separate run with rst_n pulsed low at cycle 4 -> all outputs 0 immediately and no done.
